// File: rtl/fft_butterfly_if.sv
// Operand/result bundle for the radix-2 butterfly: valid/ready on the operand side and on the result side.
interface fft_butterfly_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a_re;
  logic [7:0] a_im;
  logic [7:0] b_re;
  logic [7:0] b_im;
  logic [7:0] rew;
  logic [7:0] imw;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] x_re;
  logic [7:0] x_im;
  logic [7:0] y_re;
  logic [7:0] y_im;

  modport master (
    output in_valid, a_re, a_im, b_re, b_im, rew, imw, out_ready,
    input  in_ready, out_valid, x_re, x_im, y_re, y_im
  );

  modport slave (
    input  in_valid, a_re, a_im, b_re, b_im, rew, imw, out_ready,
    output in_ready, out_valid, x_re, x_im, y_re, y_im
  );
endinterface

// File: rtl/fft_butterfly.sv
// Radix-2 DIT butterfly, Q1.7 in/out, 3 register stages (operands, products, saturated results).
// One global advance enable stalls every stage together while a result waits; in_ready = advance.
module fft_butterfly (
  input  logic           clk,
  input  logic           reset,
  fft_butterfly_if.slave bus
);

  logic adv;

  logic              s1_vld;
  logic signed [7:0] s1_a_re, s1_a_im, s1_b_re, s1_b_im, s1_rew, s1_imw;

  logic              s2_vld;
  logic signed [7:0] s2_a_re, s2_a_im;
  logic signed [15:0] s2_rr, s2_ii, s2_ri, s2_ir;

  logic signed [16:0] p_re, p_im;
  logic signed [9:0]  bw_re, bw_im;
  logic signed [10:0] sum_xr, sum_xi, sum_yr, sum_yi;

  logic       s3_vld;
  logic [7:0] x_re_q, x_im_q, y_re_q, y_im_q;

  function automatic logic [7:0] sat8(input logic signed [10:0] v);
    if (v > 11'sd127)
      return 8'h7F;
    else if (v < -11'sd128)
      return 8'h80;
    else
      return v[7:0];
  endfunction

  assign adv           = !s3_vld || bus.out_ready;
  assign bus.in_ready  = adv;
  assign bus.out_valid = s3_vld;
  assign bus.x_re      = x_re_q;
  assign bus.x_im      = x_im_q;
  assign bus.y_re      = y_re_q;
  assign bus.y_im      = y_im_q;

  // Stage 1: operand capture
  always_ff @(posedge clk) begin
    if (reset)
      s1_vld <= 1'b0;
    else if (adv)
      s1_vld <= bus.in_valid;
  end

  always_ff @(posedge clk) begin
    if (adv && bus.in_valid) begin
      s1_a_re <= bus.a_re;
      s1_a_im <= bus.a_im;
      s1_b_re <= bus.b_re;
      s1_b_im <= bus.b_im;
      s1_rew  <= bus.rew;
      s1_imw  <= bus.imw;
    end
  end

  // Stage 2: the four partial products, kept separate so the add lands in stage 3
  always_ff @(posedge clk) begin
    if (reset)
      s2_vld <= 1'b0;
    else if (adv)
      s2_vld <= s1_vld;
  end

  always_ff @(posedge clk) begin
    if (adv && s1_vld) begin
      s2_a_re <= s1_a_re;
      s2_a_im <= s1_a_im;
      s2_rr   <= s1_b_re * s1_rew;
      s2_ii   <= s1_b_im * s1_imw;
      s2_ri   <= s1_b_re * s1_imw;
      s2_ir   <= s1_b_im * s1_rew;
    end
  end

  // Stage 3 datapath: |bw| can reach 255, so x/y need the clamp
  always_comb begin
    p_re   = {s2_rr[15], s2_rr} - {s2_ii[15], s2_ii};
    p_im   = {s2_ri[15], s2_ri} + {s2_ir[15], s2_ir};
    bw_re  = p_re[16:7];
    bw_im  = p_im[16:7];
    sum_xr = {{3{s2_a_re[7]}}, s2_a_re} + {bw_re[9], bw_re};
    sum_xi = {{3{s2_a_im[7]}}, s2_a_im} + {bw_im[9], bw_im};
    sum_yr = {{3{s2_a_re[7]}}, s2_a_re} - {bw_re[9], bw_re};
    sum_yi = {{3{s2_a_im[7]}}, s2_a_im} - {bw_im[9], bw_im};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s3_vld <= 1'b0;
      x_re_q <= 8'h00;
      x_im_q <= 8'h00;
      y_re_q <= 8'h00;
      y_im_q <= 8'h00;
    end else if (adv) begin
      s3_vld <= s2_vld;
      if (s2_vld) begin
        x_re_q <= sat8(sum_xr >>> 1);
        x_im_q <= sat8(sum_xi >>> 1);
        y_re_q <= sat8(sum_yr >>> 1);
        y_im_q <= sat8(sum_yi >>> 1);
      end else begin
        x_re_q <= 8'h00;
        x_im_q <= 8'h00;
        y_re_q <= 8'h00;
        y_im_q <= 8'h00;
      end
    end
  end

endmodule

// File: tb/tb_fft_butterfly.sv
// Bench for fft_butterfly: arithmetic reference model + scoreboard checked every cycle, plus directed literal cases.
module tb_fft_butterfly;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fft_butterfly_if bus ();

  fft_butterfly dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int passes = 0;
  int n_out  = 0;
  logic [31:0] expq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp)
      passes++;
    else
      $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic logic [7:0] clamp8(input int v);
    int c;
    c = (v > 127) ? 127 : ((v < -128) ? -128 : v);
    return c[7:0];
  endfunction

  // Plain integer butterfly: packed as {x_re, x_im, y_re, y_im}
  function automatic logic [31:0] model(input logic [7:0] ar, ai, br, bi, rw, iw);
    int a_r, a_i, p_r, p_i, bw_r, bw_i;
    a_r  = int'($signed(ar));
    a_i  = int'($signed(ai));
    p_r  = int'($signed(br)) * int'($signed(rw)) - int'($signed(bi)) * int'($signed(iw));
    p_i  = int'($signed(br)) * int'($signed(iw)) + int'($signed(bi)) * int'($signed(rw));
    bw_r = p_r >>> 7;
    bw_i = p_i >>> 7;
    return {clamp8((a_r + bw_r) >>> 1), clamp8((a_i + bw_i) >>> 1),
            clamp8((a_r - bw_r) >>> 1), clamp8((a_i - bw_i) >>> 1)};
  endfunction

  function automatic logic [31:0] outs();
    return {bus.x_re, bus.x_im, bus.y_re, bus.y_im};
  endfunction

  // Scoreboard: inputs are only changed at posedge+1, so negedge values equal the values at the next edge.
  always @(negedge clk) begin
    if (reset) begin
      expq.delete();
    end else begin
      chk("in_ready_rule", {31'b0, bus.in_ready}, {31'b0, !bus.out_valid || bus.out_ready});
      if (bus.out_valid) begin
        if (expq.size() == 0) begin
          chk("spurious_result", outs(), 32'hDEAD_BEEF);
        end else begin
          chk("result_order", outs(), expq[0]);
          if (bus.out_ready) begin
            void'(expq.pop_front());
            n_out++;
          end
        end
      end else begin
        chk("idle_outputs_zero", outs(), 32'h0);
      end
      if (bus.in_valid && bus.in_ready)
        expq.push_back(model(bus.a_re, bus.a_im, bus.b_re, bus.b_im, bus.rew, bus.imw));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic send(input logic [7:0] ar, ai, br, bi, rw, iw);
    bit ok;
    int n;
    n = 0;
    bus.a_re = ar; bus.a_im = ai; bus.b_re = br; bus.b_im = bi;
    bus.rew  = rw; bus.imw  = iw;
    bus.in_valid = 1'b1;
    do begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 50);
    if (!ok)
      chk("accept_timeout", 32'd0, 32'd1);
    bus.in_valid = 1'b0;
  endtask

  // Rising edges counted from the accepting edge (inclusive) to the one after which out_valid is seen.
  task automatic run_case(input string name, input logic [7:0] ar, ai, br, bi, rw, iw,
                          input logic [31:0] lit);
    int edges;
    chk({name, "_model"}, model(ar, ai, br, bi, rw, iw), lit);
    send(ar, ai, br, bi, rw, iw);
    edges = 1;
    forever begin
      @(negedge clk);
      if (bus.out_valid || edges >= 20) break;
      @(posedge clk);
      edges++;
    end
    chk({name, "_latency"}, edges, 32'd3);
    chk({name, "_outputs"}, outs(), lit);
    @(posedge clk);
    #1;
  endtask

  logic [7:0] bp_dat [10][6];

  initial begin
    reset = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    bus.a_re = '0; bus.a_im = '0; bus.b_re = '0; bus.b_im = '0; bus.rew = '0; bus.imw = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("reset_outputs", outs(), 32'h0);
    reset = 1'b0;
    @(negedge clk);
    chk("in_ready_after_reset", {31'b0, bus.in_ready}, 32'd1);
    @(posedge clk);
    #1;

    // Directed literal cases
    run_case("w0",      8'h20, 8'h00, 8'h40, 8'h00, 8'h7F, 8'h00, 32'h2F00_F000);
    run_case("w2",      8'h00, 8'h00, 8'h40, 8'h00, 8'h00, 8'h80, 32'h00E0_0020);
    // bw_re = 127 here, so x_re only just reaches +127; bw_im = 128
    run_case("sat_edge", 8'h7F, 8'h00, 8'h00, 8'h80, 8'h80, 8'h7F, 32'h7F40_00C0);
    // bw_re = +255: x_re clamps to +127, y_re = -64
    run_case("sat_pos", 8'h7F, 8'h00, 8'h80, 8'h80, 8'h80, 8'h7F, 32'h7F00_C0FF);
    // bw_re = -255: x_re clamps to -128, y_re = +63
    run_case("sat_neg", 8'h80, 8'h00, 8'h80, 8'h80, 8'h7F, 8'h80, 32'h8000_3FFF);

    // Throughput: 8 back-to-back sets, out_valid high on 8 consecutive cycles
    bus.out_ready = 1'b1;
    fork
      begin
        for (int i = 0; i < 8; i++)
          send(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      end
      begin
        int waits;
        waits = 0;
        do begin
          @(negedge clk);
          waits++;
        end while (!(bus.in_valid && bus.in_ready) && waits < 20);
        for (int j = 1; j <= 11; j++) begin
          @(negedge clk);
          chk($sformatf("tput_valid_%0d", j), {31'b0, bus.out_valid},
              (j >= 3 && j <= 10) ? 32'd1 : 32'd0);
        end
      end
    join
    @(posedge clk);
    #1;

    // Backpressure: 4-cycle stall right after the first result appears
    begin
      int sent, base, stall;
      logic [31:0] snap;
      sent = 0; base = n_out; stall = -1; snap = '0;
      for (int i = 0; i < 10; i++)
        for (int k = 0; k < 6; k++)
          bp_dat[i][k] = 8'($urandom);
      for (int cyc = 0; cyc < 80 && (sent < 10 || expq.size() > 0); cyc++) begin
        bus.in_valid = (sent < 10);
        if (sent < 10) begin
          bus.a_re = bp_dat[sent][0]; bus.a_im = bp_dat[sent][1];
          bus.b_re = bp_dat[sent][2]; bus.b_im = bp_dat[sent][3];
          bus.rew  = bp_dat[sent][4]; bus.imw  = bp_dat[sent][5];
        end
        bus.out_ready = !(stall > 0);
        @(negedge clk);
        if (stall > 0) begin
          chk("bp_in_ready_low", {31'b0, bus.in_ready}, 32'd0);
          chk("bp_out_valid_held", {31'b0, bus.out_valid}, 32'd1);
          if (stall == 4)
            snap = outs();
          else
            chk("bp_outputs_frozen", outs(), snap);
          stall--;
        end else if (stall < 0 && bus.out_valid) begin
          stall = 4;
        end
        if (bus.in_valid && bus.in_ready)
          sent++;
        @(posedge clk);
        #1;
      end
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      chk("bp_delivered", n_out - base, 32'd10);
      chk("bp_drained", expq.size(), 32'd0);
    end

    // Mid-operation reset with three sets in flight
    begin
      int stale;
      stale = 0;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 3; i++)
        send(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      chk("rst_mid_out_valid", {31'b0, bus.out_valid}, 32'd0);
      chk("rst_mid_outputs", outs(), 32'h0);
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        if (bus.out_valid) stale++;
      end
      chk("rst_mid_no_stale", stale, 32'd0);
      @(posedge clk);
      #1;
    end

    // Recovery after the mid-operation reset
    run_case("w0_again", 8'h20, 8'h00, 8'h40, 8'h00, 8'h7F, 8'h00, 32'h2F00_F000);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
